// File: rtl/ofdm_frame_sequencer.sv
// Show-ahead FIFO holding kept samples on their way to the FFT.
// Latency: an accepted write is visible at the head on the following cycle.
// Backpressure: a write is refused only when full with no read in the same cycle.
module ofdm_seq_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DW-1:0]          wr_dat,
  output logic                   wr_ok,
  input  logic                   rd_en,
  output logic [DW-1:0]          rd_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          rd_fire;

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_fire = rd_en && (count != '0);
  assign wr_ok   = wr_en && ((count != FULL) || rd_fire);
  assign rd_dat  = mem[rd_ptr];

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok)   wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Frame sequencer: skips fine offset + long preamble, strips CPs, frames FFT windows.
// Latency: a kept sample appears on out_* one cycle after it arrives.
// Backpressure: input cannot stall; kept samples hitting a full FIFO are dropped and flagged.
module ofdm_frame_sequencer #(
  parameter int WIDTH   = 16,
  parameter int LTF_LEN = 128,
  parameter int CP_LEN  = 16,
  parameter int FFT_LEN = 64,
  parameter int DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  input  logic             fine_done,
  input  logic [7:0]       fine_num,
  input  logic [7:0]       num_symbols,
  input  logic             fft_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             out_sop,
  output logic             out_eop,
  output logic [7:0]       sym_idx,
  output logic             frame_done,
  output logic             busy,
  output logic             overflow
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SKIP  = 3'd1;
  localparam logic [2:0] S_CP    = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int         EW       = 2 * WIDTH + 10;
  localparam int         CW       = $clog2(DEPTH) + 1;
  localparam logic [8:0] CP_LAST  = 9'(CP_LEN - 1);
  localparam logic [8:0] FFT_LAST = 9'(FFT_LEN - 1);

  logic [2:0]    state;
  logic [8:0]    cnt;
  logic [8:0]    skip_len;
  logic [7:0]    nsym;
  logic [7:0]    wr_sym;
  logic          wr_en;
  logic          wr_ok;
  logic          rd_en;
  logic [EW-1:0] wr_dat;
  logic [EW-1:0] rd_dat;
  logic [CW-1:0] fifo_cnt;
  logic [2:0]    after_skip;

  // Entry layout: {sop, eop, sym, real, imag}.
  assign wr_en      = (state == S_DATA) && in_valid;
  assign wr_dat     = {cnt == 9'd0, cnt == FFT_LAST, wr_sym, in_real, in_imag};
  assign rd_en      = out_valid && fft_ready;
  assign after_skip = (nsym == 8'd0) ? S_DRAIN : S_CP;

  ofdm_seq_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_dat (wr_dat),
    .wr_ok  (wr_ok),
    .rd_en  (rd_en),
    .rd_dat (rd_dat),
    .count  (fifo_cnt)
  );

  // Head fields are forced to zero while the FIFO is empty so idle outputs read clean.
  assign out_valid  = (fifo_cnt != '0);
  assign out_sop    = out_valid & rd_dat[EW-1];
  assign out_eop    = out_valid & rd_dat[EW-2];
  assign sym_idx    = out_valid ? rd_dat[EW-3 -: 8] : 8'd0;
  assign out_real   = out_valid ? rd_dat[2*WIDTH-1 -: WIDTH] : '0;
  assign out_imag   = out_valid ? rd_dat[WIDTH-1:0] : '0;
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DRAIN) && (fifo_cnt == '0);

  // Frame state machine; sample counters advance only on in_valid, even when writes drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      skip_len <= '0;
      nsym     <= '0;
      wr_sym   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (fine_done) begin
            skip_len <= {1'b0, fine_num} + 9'(LTF_LEN);
            nsym     <= num_symbols;
            overflow <= 1'b0;
            cnt      <= '0;
            wr_sym   <= '0;
            state    <= S_SKIP;
          end
        end
        S_SKIP: begin
          if (skip_len == 9'd0) begin
            state <= after_skip;
          end else if (in_valid) begin
            if (cnt == skip_len - 9'd1) begin
              cnt   <= '0;
              state <= after_skip;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        S_CP: begin
          if (in_valid) begin
            if (cnt == CP_LAST) begin
              cnt   <= '0;
              state <= S_DATA;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        S_DATA: begin
          if (in_valid) begin
            if (cnt == FFT_LAST) begin
              cnt    <= '0;
              wr_sym <= wr_sym + 8'd1;
              state  <= (wr_sym + 8'd1 == nsym) ? S_DRAIN : S_CP;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_cnt == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Self-checking bench: randomized stimulus against a sample-index reference model.
// Kept samples are predicted from offset/CP/FFT arithmetic and queued in a DEPTH-bounded model FIFO.
// Directed frames cover the basic, gapped, max-offset, backpressure, empty-frame and abort cases.
module tb_ofdm_frame_sequencer;
  localparam int LTF   = 128;
  localparam int CP    = 16;
  localparam int FFT   = 64;
  localparam int DEPTH = 16;
  localparam int SYM   = CP + FFT;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        fine_done;
  logic [7:0]  fine_num;
  logic [7:0]  num_symbols;
  logic        fft_ready;
  logic        out_valid;
  logic [15:0] out_real;
  logic [15:0] out_imag;
  logic        out_sop;
  logic        out_eop;
  logic [7:0]  sym_idx;
  logic        frame_done;
  logic        busy;
  logic        overflow;

  ofdm_frame_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .fine_done   (fine_done),
    .fine_num    (fine_num),
    .num_symbols (num_symbols),
    .fft_ready   (fft_ready),
    .out_valid   (out_valid),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .sym_idx     (sym_idx),
    .frame_done  (frame_done),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
    logic        sop;
    logic        eop;
    logic [7:0]  sym;
  } ent_t;

  ent_t mq[$];      // model of FIFO contents, head at index 0
  int   phase;      // 0 idle, 1 counting samples, 2 draining
  bit   m_ovf;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("idle_valid", out_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", frame_done, 1'b0);
      chk("idle_ovf", overflow, m_ovf);
      fine_done   = 1'b0;
      fine_num    = 8'($urandom);
      num_symbols = 8'($urandom);
      in_valid    = 1'($urandom_range(1));
      in_real     = 16'($urandom);
      in_imag     = 16'($urandom);
      fft_ready   = 1'($urandom_range(1));
    end
  endtask

  // Negative expectation arguments mean "not checked for this frame".
  task automatic run_frame(input int fnum, input int nsym, input int vmode, input bit rnd_ready,
                           input int stall_len, input bit dup_fd, input bit abort,
                           input int exp_first, input int exp_deliv, input int exp_ovf,
                           input int exp_fd_cyc);
    int n          = 0;
    int skip       = fnum + LTF;
    int last       = skip + nsym * SYM - 1;
    int stall_left = 0;
    bit stalled    = 0;
    bit dup_done   = 0;
    int dut_pops   = 0;
    int first_val  = -1;
    int fd_cyc     = -1;
    bit fin        = 0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      bit   kept;
      bit   pop;
      bit   acc;
      bit   fd_exp;
      int   p;
      ent_t e;
      @(negedge clk);
      fd_exp = (phase == 2) && (mq.size() == 0);
      chk("out_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) chk("head", {out_real, out_imag, out_sop, out_eop, sym_idx}, mq[0]);
      chk("busy", busy, phase != 0);
      chk("overflow", overflow, m_ovf);
      chk("frame_done", frame_done, fd_exp);
      if (abort && mq.size() == 8) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ovf", overflow, 1'b0);
        mq.delete();
        phase = 0;
        m_ovf = 0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      fine_done   = (cyc == 0);
      fine_num    = (cyc == 0) ? 8'(fnum) : 8'($urandom);
      num_symbols = (cyc == 0) ? 8'(nsym) : 8'($urandom);
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = cyc[0];
        default: in_valid = ($urandom_range(3) != 0);
      endcase
      if (phase == 1 && in_valid) begin
        in_real = 16'(n);
        in_imag = 16'(n) ^ 16'h5a5a;
      end else begin
        in_real = 16'($urandom);
        in_imag = 16'($urandom);
      end
      kept = 0;
      p    = -1;
      e    = '0;
      if (phase == 1 && in_valid) begin
        p = n - skip;
        if (p >= 0 && p / SYM < nsym && p % SYM >= CP) begin
          kept  = 1;
          e.re  = in_real;
          e.im  = in_imag;
          e.sop = (p % SYM == CP);
          e.eop = (p % SYM == SYM - 1);
          e.sym = 8'(p / SYM);
        end
      end
      if (dup_fd && kept && !dup_done && (p % SYM == CP + 10)) begin
        fine_done   = 1'b1;
        fine_num    = 8'd0;
        num_symbols = 8'd7;
        dup_done    = 1;
      end
      if (stall_len > 0 && kept && e.sop && e.sym == 8'd0 && !stalled) begin
        stalled    = 1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        fft_ready = 1'b0;
        stall_left--;
      end else begin
        fft_ready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
      end
      if (out_valid && fft_ready) begin
        dut_pops++;
        if (first_val < 0) first_val = int'(out_real);
      end
      // Reference model update for the edge that ends this cycle.
      pop = (mq.size() > 0) && fft_ready;
      acc = kept && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
      else if (kept) m_ovf = 1;
      if (phase == 1 && in_valid) begin
        if (n == last) phase = 2;
        n++;
      end
      if (cyc == 0) begin
        phase = 1;
        m_ovf = 0;
        n     = 0;
      end
      if (fd_exp) begin
        phase  = 0;
        fin    = 1;
        fd_cyc = cyc;
      end
    end
    chk("frame_finished", fin, 1'b1);
    if (exp_first >= 0) chk("first_kept", first_val, exp_first);
    if (exp_deliv >= 0) chk("delivered", dut_pops, exp_deliv);
    if (exp_ovf >= 0) chk("ovf_end", overflow, exp_ovf);
    if (exp_fd_cyc >= 0) chk("done_cycle", fd_cyc, exp_fd_cyc);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_real     = '0;
    in_imag     = '0;
    fine_done   = 1'b0;
    fine_num    = '0;
    num_symbols = '0;
    fft_ready   = 1'b0;
    phase       = 0;
    m_ovf       = 0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_sop", out_sop, 1'b0);
    chk("rst_eop", out_eop, 1'b0);
    chk("rst_sym", sym_idx, 8'd0);
    chk("rst_real", out_real, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    // basic frame: first kept sample 5+128+16 = 149
    run_frame(5, 2, 0, 0, 0, 0, 0, 149, 128, 0, -1);
    idle(2);
    // gapped input keeps the same sample values
    run_frame(5, 2, 1, 0, 0, 0, 0, 149, 128, 0, -1);
    idle(2);
    // max offset: 255+128+16 = 399 needs the 9-bit skip
    run_frame(255, 1, 0, 0, 0, 0, 0, 399, 64, 0, -1);
    idle(2);
    // 10-cycle stall fits in 16 entries
    run_frame(5, 2, 0, 0, 10, 0, 0, 149, 128, 0, -1);
    idle(2);
    // 20-cycle stall: 20 writes against 16 slots loses 4
    run_frame(5, 2, 0, 0, 20, 0, 0, 149, 124, 1, -1);
    idle(2);
    // empty frame: 130 skip samples in cycles 1..130, frame_done in the first drain cycle
    run_frame(2, 0, 0, 0, 0, 0, 0, -1, 0, 0, 131);
    idle(2);
    // second fine_done in DATA must be ignored
    run_frame(5, 2, 2, 0, 0, 1, 0, 149, 128, 0, -1);
    idle(2);
    // abort with 8 entries held, then a clean frame
    run_frame(5, 2, 0, 0, 30, 0, 1, -1, -1, -1, -1);
    idle(3);
    run_frame(5, 2, 0, 0, 0, 0, 0, 149, 128, 0, -1);
    idle(2);
    for (int t = 0; t < 6; t++) begin
      run_frame($urandom_range(255), $urandom_range(3), 2, 1, 0, 0, 0, -1, -1, -1, -1);
      idle(2);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
